mem_write_buffer: RTL and testbench

- 4-entry store FIFO that sits directly upstream of the 64x32 dual-port distributed RAM (dist_mem_gen_test).
- Accepts CPU stores through a valid/ready handshake and drains them one per cycle into the RAM's write port (a/d/we).
- Drives the RAM read port dpra and returns read data with store-to-load forwarding, so reads always see pending stores.

---
 rtl/mem_buf_pkg.sv | 15 +
 rtl/fwd_match.sv | 38 +++
 rtl/mem_write_buffer.sv | 92 +++++++++
 tb/tb_mem_write_buffer.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_buf_pkg.sv
// Shared definitions for the store write buffer and its forwarding matcher.
package mem_buf_pkg;

  localparam int DEPTH = 4;
  localparam int AW    = 6;
  localparam int DW    = 32;
  localparam int PTR_W = $clog2(DEPTH);

  // One buffered store: target RAM address and the data to write there.
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

endpackage

// File: rtl/fwd_match.sv
// Priority matcher: finds the youngest valid buffered store whose address
// equals rd_addr and returns its data.
module fwd_match
  import mem_buf_pkg::*;
#(
  parameter int DEPTH = mem_buf_pkg::DEPTH,
  parameter int AW    = mem_buf_pkg::AW,
  parameter int DW    = mem_buf_pkg::DW,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  entry_t           entries [DEPTH],
  input  logic [PTR_W-1:0] head,
  input  logic [PTR_W:0]   count,
  input  logic [AW-1:0]    rd_addr,
  output logic             hit,
  output logic [DW-1:0]    hit_data
);

  logic [PTR_W-1:0] idx;

  // Walk oldest to youngest and let later matches override earlier ones, which
  // is the same as taking the first match when searching youngest first.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (((PTR_W+1)'(i) < count) && (entries[idx].addr == rd_addr)) begin
        hit      = 1'b1;
        hit_data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/mem_write_buffer.sv
// Store FIFO in front of a dual-port distributed RAM. Stores drain into the RAM
// write port one per cycle; reads see pending stores through forwarding.
module mem_write_buffer
  import mem_buf_pkg::*;
#(
  parameter int DEPTH = mem_buf_pkg::DEPTH,
  parameter int AW    = mem_buf_pkg::AW,
  parameter int DW    = mem_buf_pkg::DW,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [AW-1:0]  in_addr,
  input  logic [DW-1:0]  in_data,
  input  logic           drain_en,
  output logic [AW-1:0]  mem_a,
  output logic [DW-1:0]  mem_d,
  output logic           mem_we,
  input  logic [AW-1:0]  rd_addr,
  output logic [DW-1:0]  rd_data,
  output logic [AW-1:0]  mem_dpra,
  input  logic [DW-1:0]  mem_dpo,
  output logic [PTR_W:0] count,
  output logic           empty
);

  entry_t           entries [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             push;
  logic             pop;
  logic             hit;
  logic [DW-1:0]    hit_data;

  // Handshake and drain decisions come only from registered occupancy, so
  // in_ready never depends on drain_en in the same cycle. The write strobe is
  // held off during reset so discarded stores never reach the RAM.
  always_comb begin
    in_ready = (count != (PTR_W+1)'(DEPTH));
    empty    = (count == '0);
    push     = in_valid && in_ready;
    pop      = drain_en && !empty && !rst;
    mem_we   = pop;
    mem_a    = empty ? '0 : entries[head].addr;
    mem_d    = empty ? '0 : entries[head].data;
  end

  // Pointer and occupancy registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    // NOTE: entry contents are deliberately not reset; count alone decides
    // which entries are valid, and leaving them out of reset keeps the array
    // mappable onto plain distributed RAM.
    if (push) entries[tail] <= '{addr: in_addr, data: in_data};
  end

  fwd_match #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_fwd_match (
    .entries  (entries),
    .head     (head),
    .count    (count),
    .rd_addr  (rd_addr),
    .hit      (hit),
    .hit_data (hit_data)
  );

  // The RAM read port always looks at rd_addr; a buffer hit overrides it.
  always_comb begin
    mem_dpra = rd_addr;
    rd_data  = hit ? hit_data : mem_dpo;
  end

endmodule

// File: tb/tb_mem_write_buffer.sv
// Directed self-checking bench for mem_write_buffer with a behavioural model
// of the 64x32 dual-port distributed RAM attached to its memory ports.
module tb_mem_write_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_addr;
  logic [31:0] in_data;
  logic        drain_en;
  logic [5:0]  mem_a;
  logic [31:0] mem_d;
  logic        mem_we;
  logic [5:0]  rd_addr;
  logic [31:0] rd_data;
  logic [5:0]  mem_dpra;
  logic [31:0] mem_dpo;
  logic [2:0]  count;
  logic        empty;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;

  logic [31:0] ram [64];
  logic        ram_clear;

  always #5 clk = ~clk;

  mem_write_buffer dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_addr  (in_addr),
    .in_data  (in_data),
    .drain_en (drain_en),
    .mem_a    (mem_a),
    .mem_d    (mem_d),
    .mem_we   (mem_we),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .mem_dpra (mem_dpra),
    .mem_dpo  (mem_dpo),
    .count    (count),
    .empty    (empty)
  );

  // RAM model: synchronous write port, asynchronous read port. Preloaded with
  // zeros except a marker word at the top address.
  always @(posedge clk) begin
    if (ram_clear) begin
      for (int i = 0; i < 64; i++) ram[i] <= (i == 63) ? 32'hDEAD_BEEF : 32'h0;
    end else if (mem_we) begin
      ram[mem_a] <= mem_d;
    end
  end
  assign mem_dpo = ram[mem_dpra];

  always @(negedge clk) if (mem_we) we_cnt <= we_cnt + 1;

  // Advance one clock and land 1 time unit after the edge; occupancy must
  // never leave 0..4.
  task automatic step();
    @(posedge clk);
    #1;
    checks++;
    if (count > 3'd4) begin
      errors++;
      $display("FAIL count_range: count=%0d, must be <= 4", count);
    end
  endtask

  task automatic test_reset();
    rd_addr = 6'd63;
    #1;
    checks++;
    if (in_ready !== 1'b1 || empty !== 1'b1 || mem_we !== 1'b0 || count !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: ready=%b empty=%b we=%b count=%0d, expected 1 1 0 0",
               in_ready, empty, mem_we, count);
    end
    checks++;
    if (mem_a !== 6'd0 || mem_d !== 32'h0) begin
      errors++;
      $display("FAIL reset_mem_port: a=%0d d=%h, expected 0 0", mem_a, mem_d);
    end
    checks++;
    if (rd_data !== 32'hDEAD_BEEF || mem_dpra !== 6'd63) begin
      errors++;
      $display("FAIL reset_read: rd_data=%h dpra=%0d, expected deadbeef 63", rd_data, mem_dpra);
    end
  endtask

  task automatic test_forward_basic();
    drain_en = 1'b0;
    in_valid = 1'b1;
    in_addr  = 6'd1;
    in_data  = 32'h1111;
    rd_addr  = 6'd1;
    #1;
    checks++;
    if (rd_data !== 32'h0) begin
      errors++;
      $display("FAIL no_fwd_of_input: rd_data=%h, expected 0", rd_data);
    end
    step();
    in_addr = 6'd2;
    in_data = 32'h2222;
    step();
    in_valid = 1'b0;
    rd_addr  = 6'd2;
    #1;
    checks++;
    if (count !== 3'd2 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL fwd_hold: count=%0d we=%b, expected 2 0", count, mem_we);
    end
    checks++;
    if (rd_data !== 32'h2222 || mem_dpo !== 32'h0) begin
      errors++;
      $display("FAIL fwd_addr2: rd_data=%h ram=%h, expected 2222 0", rd_data, mem_dpo);
    end
    rd_addr  = 6'd1;
    drain_en = 1'b1;
    #1;
    checks++;
    if (mem_we !== 1'b1 || mem_a !== 6'd1 || mem_d !== 32'h1111 || rd_data !== 32'h1111) begin
      errors++;
      $display("FAIL fwd_drain_head: we=%b a=%0d d=%h rd=%h, expected 1 1 1111 1111",
               mem_we, mem_a, mem_d, rd_data);
    end
    step();
    checks++;
    if (mem_we !== 1'b1 || mem_a !== 6'd2 || mem_d !== 32'h2222) begin
      errors++;
      $display("FAIL fwd_drain_second: we=%b a=%0d d=%h, expected 1 2 2222", mem_we, mem_a, mem_d);
    end
    step();
    drain_en = 1'b0;
    rd_addr  = 6'd2;
    #1;
    checks++;
    if (empty !== 1'b1 || mem_we !== 1'b0 || rd_data !== 32'h2222) begin
      errors++;
      $display("FAIL fwd_after_drain: empty=%b we=%b rd=%h, expected 1 0 2222", empty, mem_we, rd_data);
    end
  endtask

  task automatic test_full();
    drain_en = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_addr = 6'(10 + i);
      in_data = 32'h100 + 32'(i);
      step();
    end
    checks++;
    if (count !== 3'd4 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_state: count=%0d ready=%b, expected 4 0", count, in_ready);
    end
    in_addr = 6'd20;
    in_data = 32'hFFFF;
    step();
    in_valid = 1'b0;
    checks++;
    if (count !== 3'd4) begin
      errors++;
      $display("FAIL full_ignore: count=%0d, expected 4", count);
    end
    drain_en = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0 || mem_we !== 1'b1) begin
      errors++;
      $display("FAIL full_no_refill: ready=%b we=%b, expected 0 1", in_ready, mem_we);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem_we !== 1'b1 || mem_a !== 6'(10 + i) || mem_d !== 32'h100 + 32'(i)) begin
        errors++;
        $display("FAIL full_drain_%0d: we=%b a=%0d d=%h, expected 1 %0d %h",
                 i, mem_we, mem_a, mem_d, 10 + i, 32'h100 + 32'(i));
      end
      step();
      if (i == 0) begin
        checks++;
        if (in_ready !== 1'b1 || count !== 3'd3) begin
          errors++;
          $display("FAIL full_ready_rise: ready=%b count=%0d, expected 1 3", in_ready, count);
        end
      end
    end
    drain_en = 1'b0;
    rd_addr  = 6'd13;
    #1;
    checks++;
    if (empty !== 1'b1 || rd_data !== 32'h103) begin
      errors++;
      $display("FAIL full_readback: empty=%b rd=%h, expected 1 103", empty, rd_data);
    end
    rd_addr = 6'd20;
    #1;
    checks++;
    if (rd_data !== 32'h0) begin
      errors++;
      $display("FAIL full_fifth_dropped: rd=%h, expected 0", rd_data);
    end
  endtask

  task automatic test_duplicate();
    drain_en = 1'b0;
    in_valid = 1'b1;
    in_addr  = 6'd5;
    in_data  = 32'hAAAA;
    step();
    in_data = 32'hBBBB;
    step();
    in_valid = 1'b0;
    rd_addr  = 6'd5;
    #1;
    checks++;
    if (rd_data !== 32'hBBBB) begin
      errors++;
      $display("FAIL dup_youngest: rd=%h, expected bbbb", rd_data);
    end
    drain_en = 1'b1;
    step();
    checks++;
    if (count !== 3'd1 || rd_data !== 32'hBBBB || mem_dpo !== 32'hAAAA) begin
      errors++;
      $display("FAIL dup_mid_drain: count=%0d rd=%h ram=%h, expected 1 bbbb aaaa", count, rd_data, mem_dpo);
    end
    step();
    drain_en = 1'b0;
    #1;
    checks++;
    if (empty !== 1'b1 || rd_data !== 32'hBBBB || mem_dpo !== 32'hBBBB) begin
      errors++;
      $display("FAIL dup_final: empty=%b rd=%h ram=%h, expected 1 bbbb bbbb", empty, rd_data, mem_dpo);
    end
  endtask

  task automatic test_back_to_back();
    int peak;
    peak     = 0;
    drain_en = 1'b1;
    in_valid = 1'b1;
    for (int a = 0; a < 16; a++) begin
      in_addr = 6'(a);
      in_data = 32'(a) * 32'h1111;
      #1;
      if (in_ready !== 1'b1) peak = 99;
      step();
      if (int'(count) > peak) peak = int'(count);
    end
    in_valid = 1'b0;
    step();
    drain_en = 1'b0;
    checks++;
    if (peak > 1 || empty !== 1'b1) begin
      errors++;
      $display("FAIL b2b_occupancy: peak=%0d empty=%b, expected <=1 1", peak, empty);
    end
    for (int a = 0; a < 16; a++) begin
      rd_addr = 6'(a);
      #1;
      checks++;
      if (rd_data !== 32'(a) * 32'h1111) begin
        errors++;
        $display("FAIL b2b_readback_%0d: rd=%h, expected %h", a, rd_data, 32'(a) * 32'h1111);
      end
    end
  endtask

  task automatic test_reset_mid();
    int we_before;
    drain_en = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_addr = 6'(30 + i);
      in_data = 32'h3030 + 32'(i);
      step();
    end
    in_valid = 1'b0;
    we_before = we_cnt;
    checks++;
    if (count !== 3'd3) begin
      errors++;
      $display("FAIL rstmid_fill: count=%0d, expected 3", count);
    end
    rst      = 1'b1;
    drain_en = 1'b1;
    #1;
    checks++;
    if (mem_we !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_we_in_reset: we=%b, expected 0", mem_we);
    end
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (count !== 3'd0 || empty !== 1'b1 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_state: count=%0d empty=%b we=%b, expected 0 1 0", count, empty, mem_we);
    end
    step();
    step();
    drain_en = 1'b0;
    checks++;
    if (we_cnt !== we_before) begin
      errors++;
      $display("FAIL rstmid_no_write: we pulses=%0d, expected %0d", we_cnt, we_before);
    end
    for (int i = 0; i < 3; i++) begin
      rd_addr = 6'(30 + i);
      #1;
      checks++;
      if (rd_data !== 32'h0) begin
        errors++;
        $display("FAIL rstmid_ram_%0d: rd=%h, expected 0", 30 + i, rd_data);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    ram_clear = 1'b1;
    in_valid  = 1'b0;
    in_addr   = '0;
    in_data   = '0;
    drain_en  = 1'b0;
    rd_addr   = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    ram_clear = 1'b0;
    test_reset();
    test_forward_basic();
    test_full();
    test_duplicate();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
